// File: rtl/flex_stp_pkg.sv
// Shared types and helpers for the flex STP word receiver.
// Contents: bit-order enum, reset-fill helper.
// Imported by the shift core and the top level.
package flex_stp_pkg;

  // Bit order for one word; the value matches the msb_first pin.
  typedef enum logic {
    STP_LSB_FIRST = 1'b0,
    STP_MSB_FIRST = 1'b1
  } stp_order_t;

  // Fill bit used for the shift and output registers at reset/clear.
  // Callers replicate it to NUM_BITS, which keeps the function width-agnostic.
  function automatic logic reset_fill(input int reset_ones);
    return (reset_ones != 0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/flex_stp_word_rx_if.sv
// Bus bundle between the bit front end / word consumer and flex_stp_word_rx.
// master: drives serial control and word_ready; slave: the receiver itself.
// Ports: clear, shift_enable, serial_in, msb_first, word_ready -> rx; shift_data, bit_count, word_data, word_valid, overrun <- rx.
interface flex_stp_word_rx_if #(
  parameter int NUM_BITS = 8
);
  localparam int CNT_W = $clog2(NUM_BITS);

  logic                clear;
  logic                shift_enable;
  logic                serial_in;
  logic                msb_first;
  logic [NUM_BITS-1:0] shift_data;
  logic [CNT_W-1:0]    bit_count;
  logic [NUM_BITS-1:0] word_data;
  logic                word_valid;
  logic                word_ready;
  logic                overrun;

  modport master (
    output clear, shift_enable, serial_in, msb_first, word_ready,
    input  shift_data, bit_count, word_data, word_valid, overrun
  );

  modport slave (
    input  clear, shift_enable, serial_in, msb_first, word_ready,
    output shift_data, bit_count, word_data, word_valid, overrun
  );

endinterface

// File: rtl/flex_stp_shift_core.sv
// Shift register, bit counter and latched bit order for one serial word.
// Ports: clk/n_rst, clear_i, shift_enable_i, serial_in_i, msb_first_i in;
//        shift_data_o, bit_count_o, word_done_o (pulse on final shift), word_o (assembled word) out.
module flex_stp_shift_core
  import flex_stp_pkg::*;
#(
  parameter int NUM_BITS   = 8,
  parameter int RESET_ONES = 1,
  localparam int CNT_W     = $clog2(NUM_BITS)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear_i,
  input  logic                shift_enable_i,
  input  logic                serial_in_i,
  input  logic                msb_first_i,
  output logic [NUM_BITS-1:0] shift_data_o,
  output logic [CNT_W-1:0]    bit_count_o,
  output logic                word_done_o,
  output logic [NUM_BITS-1:0] word_o
);

  localparam logic [NUM_BITS-1:0] SR_RST   = {NUM_BITS{reset_fill(RESET_ONES)}};
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(NUM_BITS - 1);

  logic [NUM_BITS-1:0] sr_q, sr_d, sr_next;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  stp_order_t          mode_q, mode_d, mode_eff;
  logic                last_bit;

  // The order pin is only honoured on the first bit of a word; after that
  // the latched order rules so mid-word toggles cannot scramble the word.
  assign mode_eff = (cnt_q == '0) ? stp_order_t'(msb_first_i) : mode_q;
  assign last_bit = (cnt_q == CNT_LAST);

  always_comb begin
    if (mode_eff == STP_MSB_FIRST) sr_next = {sr_q[NUM_BITS-2:0], serial_in_i};
    else                           sr_next = {serial_in_i, sr_q[NUM_BITS-1:1]};
  end

  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    word_done_o = 1'b0;
    if (clear_i) begin
      sr_d   = SR_RST;
      cnt_d  = '0;
      mode_d = STP_MSB_FIRST;
    end else if (shift_enable_i) begin
      sr_d        = sr_next;
      // Explicit wrap: NUM_BITS need not be a power of two.
      cnt_d       = last_bit ? '0 : cnt_q + CNT_W'(1);
      mode_d      = mode_eff;
      word_done_o = last_bit;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr_q   <= SR_RST;
      cnt_q  <= '0;
      mode_q <= STP_MSB_FIRST;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  assign shift_data_o = sr_q;
  assign bit_count_o  = cnt_q;
  // The completed word is the value the shift register is about to take.
  assign word_o       = sr_next;

endmodule

// File: rtl/flex_stp_word_rx.sv
// Serial-to-parallel word receiver with held output word, valid/ready and sticky overrun.
// Ports: clk, n_rst plain; bus (slave modport) carries serial input, order select,
//        clear, live shift view, held word with valid/ready handshake, overrun flag.
module flex_stp_word_rx
  import flex_stp_pkg::*;
#(
  parameter int NUM_BITS   = 8,
  parameter int RESET_ONES = 1
) (
  input  logic               clk,
  input  logic               n_rst,
  flex_stp_word_rx_if.slave  bus
);

  localparam logic [NUM_BITS-1:0] WD_RST = {NUM_BITS{reset_fill(RESET_ONES)}};

  logic                word_done;
  logic [NUM_BITS-1:0] word_asm;
  logic [NUM_BITS-1:0] wd_q, wd_d;
  logic                wv_q, wv_d;
  logic                ov_q, ov_d;
  logic                xfer;

  flex_stp_shift_core #(
    .NUM_BITS   (NUM_BITS),
    .RESET_ONES (RESET_ONES)
  ) u_core (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear_i        (bus.clear),
    .shift_enable_i (bus.shift_enable),
    .serial_in_i    (bus.serial_in),
    .msb_first_i    (bus.msb_first),
    .shift_data_o   (bus.shift_data),
    .bit_count_o    (bus.bit_count),
    .word_done_o    (word_done),
    .word_o         (word_asm)
  );

  assign xfer = wv_q && bus.word_ready;

  always_comb begin
    wd_d = wd_q;
    wv_d = wv_q;
    ov_d = ov_q;
    if (bus.clear) begin
      wd_d = WD_RST;
      wv_d = 1'b0;
      ov_d = 1'b0;
    end else begin
      if (xfer) wv_d = 1'b0;
      if (word_done) begin
        // A slot is free if empty or being drained this very cycle.
        if (!wv_q || bus.word_ready) begin
          wd_d = word_asm;
          wv_d = 1'b1;
        end else begin
          ov_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_q <= WD_RST;
      wv_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      wv_q <= wv_d;
      ov_q <= ov_d;
    end
  end

  assign bus.word_data  = wd_q;
  assign bus.word_valid = wv_q;
  assign bus.overrun    = ov_q;

endmodule

// File: tb/tb_flex_stp_word_rx.sv
// Self-checking bench for flex_stp_word_rx (NUM_BITS=8, RESET_ONES=1).
// Directed scenarios with fixed expected words plus a randomized run against an arithmetic model.
// Model tracks shift value, bit count, latched order, held word, valid and overrun.
module tb_flex_stp_word_rx;
  localparam int N   = 8;
  localparam int CW  = $clog2(N);
  localparam int RST = (1 << N) - 1;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  flex_stp_word_rx_if #(.NUM_BITS(N)) bus ();

  flex_stp_word_rx #(.NUM_BITS(N), .RESET_ONES(1)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int vec = 0;
  int err = 0;

  // Reference model state
  int m_sr, m_cnt, m_mode, m_wd, m_wv, m_ov;

  task automatic model_reset();
    m_sr = RST; m_cnt = 0; m_mode = 1; m_wd = RST; m_wv = 0; m_ov = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs, then clock the DUT.
  task automatic step();
    int b, done, rdy, xfer;
    done = 0;
    b    = int'(bus.serial_in);
    rdy  = int'(bus.word_ready);
    if (bus.clear) begin
      model_reset();
    end else begin
      if (bus.shift_enable) begin
        if (m_cnt == 0) m_mode = int'(bus.msb_first);
        if (m_mode == 1) m_sr = (m_sr * 2 + b) % (1 << N);
        else             m_sr = m_sr / 2 + b * (1 << (N - 1));
        m_cnt = (m_cnt + 1) % N;
        done  = (m_cnt == 0);
      end
      xfer = m_wv & rdy;
      if (done != 0) begin
        if (m_wv == 0 || rdy == 1) begin m_wd = m_sr; m_wv = 1; end
        else m_ov = 1;
      end else if (xfer != 0) begin
        m_wv = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.shift_enable = 1'b1;
    bus.serial_in    = b;
    step();
    bus.shift_enable = 1'b0;
  endtask

  task automatic send_word(input logic [N-1:0] w, input logic msb);
    bus.msb_first = msb;
    for (int i = 0; i < N; i++) send_bit(msb ? w[N-1-i] : w[i]);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.clear = 1'b0; bus.shift_enable = 1'b0; bus.serial_in = 1'b0;
    bus.msb_first = 1'b1; bus.word_ready = 1'b0;
    model_reset();
    #12;
    vec++; if (bus.shift_data !== 8'hFF) begin err++; $display("FAIL reset_shift_data: got %h want ff", bus.shift_data); end
    vec++; if (bus.word_data !== 8'hFF) begin err++; $display("FAIL reset_word_data: got %h want ff", bus.word_data); end
    vec++; if (bus.word_valid !== 1'b0) begin err++; $display("FAIL reset_word_valid: got %b want 0", bus.word_valid); end
    vec++; if (bus.bit_count !== '0) begin err++; $display("FAIL reset_bit_count: got %0d want 0", bus.bit_count); end
    vec++; if (bus.overrun !== 1'b0) begin err++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_msb_first();
    logic [7:0] pat;
    pat = 8'b1011_0100;
    bus.word_ready = 1'b1;
    bus.msb_first  = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(pat[7-i]);
    vec++; if (bus.word_valid !== 1'b0) begin err++; $display("FAIL msb_early_valid: got %b want 0", bus.word_valid); end
    send_bit(pat[0]);
    vec++; if (bus.word_valid !== 1'b1) begin err++; $display("FAIL msb_valid: got %b want 1", bus.word_valid); end
    vec++; if (bus.word_data !== 8'hB4) begin err++; $display("FAIL msb_word: got %h want b4", bus.word_data); end
    step();
    vec++; if (bus.word_valid !== 1'b0) begin err++; $display("FAIL msb_valid_one_cycle: got %b want 0", bus.word_valid); end
  endtask

  task automatic test_lsb_gaps();
    logic [7:0] seq;
    int gaps;
    seq = 8'b1011_0100;  // element 7 sent first
    bus.word_ready = 1'b1;
    bus.msb_first  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == 2) bus.msb_first = 1'b1;
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        step();
        vec++; if (bus.bit_count !== CW'(i)) begin err++; $display("FAIL lsb_gap_count: got %0d want %0d", bus.bit_count, i); end
      end
      send_bit(seq[7-i]);
    end
    vec++; if (bus.word_data !== 8'h2D) begin err++; $display("FAIL lsb_word: got %h want 2d", bus.word_data); end
    vec++; if (bus.word_valid !== 1'b1) begin err++; $display("FAIL lsb_valid: got %b want 1", bus.word_valid); end
    step();
  endtask

  task automatic test_overrun();
    bus.word_ready = 1'b0;
    send_word(8'h12, 1'b1);
    vec++; if (bus.overrun !== 1'b0) begin err++; $display("FAIL ovr_early: got %b want 0", bus.overrun); end
    send_word(8'h34, 1'b1);
    vec++; if (bus.word_data !== 8'h12) begin err++; $display("FAIL ovr_held: got %h want 12", bus.word_data); end
    vec++; if (bus.overrun !== 1'b1) begin err++; $display("FAIL ovr_set: got %b want 1", bus.overrun); end
    bus.word_ready = 1'b1;
    step();
    bus.word_ready = 1'b0;
    vec++; if (bus.word_valid !== 1'b0) begin err++; $display("FAIL ovr_drain_valid: got %b want 0", bus.word_valid); end
    vec++; if (bus.overrun !== 1'b1) begin err++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun); end
    vec++; if (bus.word_data !== 8'h12) begin err++; $display("FAIL ovr_data_after_drain: got %h want 12", bus.word_data); end
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    vec++; if (bus.overrun !== 1'b0) begin err++; $display("FAIL ovr_clear: got %b want 0", bus.overrun); end
    vec++; if (bus.word_data !== 8'hFF) begin err++; $display("FAIL clear_word_data: got %h want ff", bus.word_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    w = 8'h56;
    bus.word_ready = 1'b0;
    send_word(8'h12, 1'b1);
    bus.msb_first = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(w[7-i]);
    bus.word_ready = 1'b1;
    send_bit(w[0]);
    vec++; if (bus.word_data !== 8'h56) begin err++; $display("FAIL b2b_word: got %h want 56", bus.word_data); end
    vec++; if (bus.word_valid !== 1'b1) begin err++; $display("FAIL b2b_valid: got %b want 1", bus.word_valid); end
    vec++; if (bus.overrun !== 1'b0) begin err++; $display("FAIL b2b_overrun: got %b want 0", bus.overrun); end
    step();
  endtask

  task automatic test_mid_word_reset();
    bus.word_ready = 1'b1;
    bus.msb_first  = 1'b0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    n_rst = 1'b0;
    #2;
    model_reset();
    vec++; if (bus.bit_count !== '0) begin err++; $display("FAIL rst_mid_count: got %0d want 0", bus.bit_count); end
    vec++; if (bus.shift_data !== 8'hFF) begin err++; $display("FAIL rst_mid_shift: got %h want ff", bus.shift_data); end
    n_rst = 1'b1;
    send_word(8'hC3, 1'b1);
    vec++; if (bus.word_data !== 8'hC3) begin err++; $display("FAIL rst_mid_word: got %h want c3", bus.word_data); end
    step();
    bus.msb_first = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    bus.clear = 1'b1;
    bus.shift_enable = 1'b1;  // clear must win over a shift
    step();
    bus.clear = 1'b0;
    bus.shift_enable = 1'b0;
    vec++; if (bus.bit_count !== '0) begin err++; $display("FAIL clr_mid_count: got %0d want 0", bus.bit_count); end
    send_word(8'hC3, 1'b0);
    vec++; if (bus.word_data !== 8'hC3) begin err++; $display("FAIL clr_mid_word: got %h want c3", bus.word_data); end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      bus.shift_enable = ($urandom_range(0, 3) != 0);
      bus.serial_in    = 1'($urandom_range(0, 1));
      bus.msb_first    = 1'($urandom_range(0, 1));
      bus.word_ready   = ($urandom_range(0, 9) < 3);
      bus.clear        = ($urandom_range(0, 99) == 0);
      step();
      vec++;
      if (bus.shift_data !== N'(m_sr) || bus.bit_count !== CW'(m_cnt) ||
          bus.word_data !== N'(m_wd) || bus.word_valid !== 1'(m_wv) ||
          bus.overrun !== 1'(m_ov)) begin
        err++;
        $display("FAIL rand_cycle_%0d: got sr=%h cnt=%0d wd=%h wv=%b ov=%b want sr=%h cnt=%0d wd=%h wv=%0d ov=%0d",
                 c, bus.shift_data, bus.bit_count, bus.word_data, bus.word_valid, bus.overrun,
                 m_sr, m_cnt, m_wd, m_wv, m_ov);
      end
    end
    bus.clear = 1'b0;
    bus.shift_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_gaps();
    test_overrun();
    test_back_to_back();
    test_mid_word_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
